// File: rtl/ram_master_pkg.sv
// Shared types for the RAM initiator: access size, initiator FSM states
// and the RAM port handshake state.
package ram_master_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        RM_IDLE,
        RM_IBUSY,
        RM_DBUSY,
        RM_DERR
    } ram_master_state_t;

    typedef enum logic [1:0] {
        RAM_FREE  = 2'd0,
        RAM_WAIT  = 2'd1,
        RAM_DONE  = 2'd2,
        RAM_ERROR = 2'd3
    } ram_state_t;

endpackage

// File: rtl/ram_master_if.sv
// Single-port RAM bus. The initiator (cpu) drives the request side and
// samples read data plus the RAM handshake state; the memory side mirrors it.
interface ram_if;
    import ram_master_pkg::*;

    logic        ren;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
    ram_state_t  state;

    modport cpu (
        output ren, wen, addr, store,
        input  load, state
    );

    modport mem (
        input  ren, wen, addr, store,
        output load, state
    );

endinterface

// File: rtl/ram_master_align.sv
// Combinational byte-lane logic: write lanes and replicated store data from
// size/offset, misalignment detection, and load extraction with extension.
module mem_align
    import ram_master_pkg::*;
(
    input  mem_size_t   size_i,
    input  logic [1:0]  off_i,
    input  logic        signed_i,
    input  logic [31:0] store_i,
    input  logic [31:0] load_i,
    output logic [3:0]  wen_o,
    output logic [31:0] store_o,
    output logic        misalign_o,
    output logic [31:0] load_o
);

    logic [31:0] shifted;

    // Lane selection, store replication and load extract for the given size.
    always_comb begin
        shifted    = load_i >> {off_i, 3'b000};
        wen_o      = 4'b1111;
        store_o    = store_i;
        misalign_o = 1'b0;
        load_o     = shifted;
        case (size_i)
            MEM_BYTE: begin
                wen_o   = 4'b0001 << off_i;
                store_o = {4{store_i[7:0]}};
                load_o  = signed_i ? {{24{shifted[7]}}, shifted[7:0]}
                                   : {24'h000000, shifted[7:0]};
            end
            MEM_HALF: begin
                wen_o      = off_i[1] ? 4'b1100 : 4'b0011;
                store_o    = {2{store_i[15:0]}};
                misalign_o = off_i[0];
                load_o     = signed_i ? {{16{shifted[15]}}, shifted[15:0]}
                                      : {16'h0000, shifted[15:0]};
            end
            default: begin
                // Size encoding 3 is treated like a word access.
                misalign_o = |off_i;
            end
        endcase
    end

endmodule

// File: rtl/ram_master.sv
// RAM initiator: arbitrates instruction fetch and data access onto one RAM
// port, holds the latched request until the RAM reports DONE (or the
// watchdog expires), and returns the aligned load word.
// Optional build macro RAM_MASTER_RR_EN: round-robin between fetch and data
// on simultaneous requests; without it data always wins.
//
//  state     | meaning
//  RM_IDLE   | no access in flight; RAM request lines low; accept a request
//  RM_IBUSY  | fetch on the RAM port, waiting for DONE or watchdog
//  RM_DBUSY  | data load/store on the RAM port, waiting for DONE or watchdog
//  RM_DERR   | misaligned data request; one-cycle faulted hit, no RAM access
module ram_master
    import ram_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        iren_i,
    input  logic [31:0] iaddr_i,
    output logic [31:0] iload_o,
    output logic        ihit_o,
    input  logic        dren_i,
    input  logic        dwen_i,
    input  logic [31:0] daddr_i,
    input  mem_size_t   dsize_i,
    input  logic        dsigned_i,
    input  logic [31:0] dstore_i,
    output logic [31:0] dload_o,
    output logic        dhit_o,
    output logic        dfault_o,
    ram_if.cpu          ram
);

    localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LOAD = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

    ram_master_state_t state_q, state_d;
    logic              ren_q, ren_d;
    logic [3:0]        wen_q, wen_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       store_q, store_d;
    mem_size_t         size_q, size_d;
    logic              sign_q, sign_d;
    logic [WDW-1:0]    wd_q, wd_d;

    logic              dreq;
    logic              grant_data;
    logic              done;
    logic              timeout;

    mem_size_t         al_size;
    logic [1:0]        al_off;
    logic [3:0]        al_wen;
    logic [31:0]       al_store;
    logic              al_mis;
    logic [31:0]       al_load;

    assign dreq = dren_i | dwen_i;

`ifdef RAM_MASTER_RR_EN
    logic prio_data_q, prio_data_d;
    assign grant_data = dreq & (~iren_i | prio_data_q);
`else
    assign grant_data = dreq;
`endif

    assign done    = (ram.state == RAM_DONE);
    // Watchdog down-counter reaches zero on the TIMEOUT-th busy cycle.
    assign timeout = (TIMEOUT != 0) && (wd_q == '0);

    // In IDLE the aligner sees the incoming request; while busy it sees the
    // latched access so the load extract uses the captured size/offset.
    assign al_size = (state_q == RM_IDLE) ? dsize_i : size_q;
    assign al_off  = (state_q == RM_IDLE) ? daddr_i[1:0] : addr_q[1:0];

    mem_align u_align (
        .size_i     (al_size),
        .off_i      (al_off),
        .signed_i   (sign_q),
        .store_i    (dstore_i),
        .load_i     (ram.load),
        .wen_o      (al_wen),
        .store_o    (al_store),
        .misalign_o (al_mis),
        .load_o     (al_load)
    );

    // RAM request lines come straight from registers: stable for the access.
    assign ram.ren   = ren_q;
    assign ram.wen   = wen_q;
    assign ram.addr  = addr_q;
    assign ram.store = store_q;

    // Next-state, request latching and combinational hit/data outputs.
    always_comb begin
        state_d  = state_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        store_d  = store_q;
        size_d   = size_q;
        sign_d   = sign_q;
        wd_d     = wd_q;
`ifdef RAM_MASTER_RR_EN
        prio_data_d = prio_data_q;
`endif
        ihit_o   = 1'b0;
        iload_o  = '0;
        dhit_o   = 1'b0;
        dload_o  = '0;
        dfault_o = 1'b0;

        case (state_q)
            RM_IDLE: begin
                ren_d = 1'b0;
                wen_d = 4'b0000;
                wd_d  = WD_LOAD;
                if (grant_data) begin
                    addr_d  = daddr_i;
                    size_d  = dsize_i;
                    sign_d  = dsigned_i;
                    store_d = al_store;
`ifdef RAM_MASTER_RR_EN
                    prio_data_d = 1'b0;
`endif
                    if (al_mis) begin
                        state_d = RM_DERR;
                    end else begin
                        state_d = RM_DBUSY;
                        ren_d   = ~dwen_i;
                        wen_d   = dwen_i ? al_wen : 4'b0000;
                    end
                end else if (iren_i) begin
                    state_d = RM_IBUSY;
                    addr_d  = {iaddr_i[31:2], 2'b00};
                    ren_d   = 1'b1;
`ifdef RAM_MASTER_RR_EN
                    prio_data_d = 1'b1;
`endif
                end
            end
            RM_IBUSY: begin
                if (done || timeout) begin
                    ihit_o  = nrst;
                    iload_o = (done && nrst) ? ram.load : '0;
                    state_d = RM_IDLE;
                    ren_d   = 1'b0;
                    wen_d   = 4'b0000;
                end else if (wd_q != '0) begin
                    wd_d = wd_q - 1'b1;
                end
            end
            RM_DBUSY: begin
                if (done || timeout) begin
                    dhit_o   = nrst;
                    dload_o  = (done && nrst) ? al_load : '0;
                    dfault_o = nrst & ~done;
                    state_d  = RM_IDLE;
                    ren_d    = 1'b0;
                    wen_d    = 4'b0000;
                end else if (wd_q != '0) begin
                    wd_d = wd_q - 1'b1;
                end
            end
            default: begin
                dhit_o   = nrst;
                dfault_o = nrst;
                state_d  = RM_IDLE;
            end
        endcase
    end

    // State and latched-request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= RM_IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 4'b0000;
            addr_q  <= '0;
            store_q <= '0;
            size_q  <= MEM_WORD;
            sign_q  <= 1'b0;
            wd_q    <= '0;
`ifdef RAM_MASTER_RR_EN
            prio_data_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            wd_q    <= wd_d;
`ifdef RAM_MASTER_RR_EN
            prio_data_q <= prio_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_master.sv
module tb_ram_master;
    import ram_master_pkg::*;

    localparam int TO = 3;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        iren = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] iload;
    logic        ihit;
    logic        dren = 1'b0;
    logic        dwen = 1'b0;
    logic [31:0] daddr = '0;
    mem_size_t   dsize = MEM_WORD;
    logic        dsigned = 1'b0;
    logic [31:0] dstore = '0;
    logic [31:0] dload;
    logic        dhit;
    logic        dfault;

    ram_if u_ram ();

    ram_master #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .iren_i    (iren),
        .iaddr_i   (iaddr),
        .iload_o   (iload),
        .ihit_o    (ihit),
        .dren_i    (dren),
        .dwen_i    (dwen),
        .daddr_i   (daddr),
        .dsize_i   (dsize),
        .dsigned_i (dsigned),
        .dstore_i  (dstore),
        .dload_o   (dload),
        .dhit_o    (dhit),
        .dfault_o  (dfault),
        .ram       (u_ram.cpu)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    // ---------------- RAM model: LAT wait cycles then DONE ----------------
    logic [31:0] ram_mem [0:255];
    int          ram_lat = 0;
    bit          ram_stall = 0;
    int          ram_cnt = 0;
    logic        ram_active;

    assign ram_active = u_ram.ren || (u_ram.wen != 4'b0000);

    always_comb begin
        u_ram.state = RAM_FREE;
        if (ram_active)
            u_ram.state = (ram_stall || ram_cnt < ram_lat) ? RAM_WAIT : RAM_DONE;
        u_ram.load = ram_mem[u_ram.addr[9:2]];
    end

    always @(posedge clk) begin
        if (!nrst) begin
            ram_cnt <= 0;
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
        end else if (ram_active) begin
            if (u_ram.state == RAM_DONE) begin
                ram_cnt <= 0;
                for (int b = 0; b < 4; b++)
                    if (u_ram.wen[b]) ram_mem[u_ram.addr[9:2]][8*b +: 8] <= u_ram.store[8*b +: 8];
            end else begin
                ram_cnt <= ram_cnt + 1;
            end
        end else begin
            ram_cnt <= 0;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit          fetch;
        bit          exp_ren;
        logic [3:0]  exp_wen;
        logic [31:0] exp_addr;
        logic [31:0] exp_store;
        logic [31:0] exp_data;
        bit          chk_data;
        bit          exp_fault;
        int          exp_cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ref_mem [0:255];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_ihit = 0;
    int          n_dhit = 0;
    logic [31:0] last_iload = '0;
    logic [31:0] last_dload = '0;
    logic        last_dfault = 1'b0;

`ifdef RAM_MASTER_RR_EN
    bit prio_data = 1'b1;
`endif

    task automatic init_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
`ifdef RAM_MASTER_RR_EN
        prio_data = 1'b1;
`endif
    endtask

    task automatic note_grant(bit is_data);
`ifdef RAM_MASTER_RR_EN
        prio_data = !is_data;
`else
        if (is_data) return;
`endif
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk_fetch(logic [31:0] a, int issue);
        exp_t e;
        e.fetch     = 1'b1;
        e.exp_ren   = 1'b1;
        e.exp_wen   = 4'b0000;
        e.exp_addr  = a & 32'hFFFF_FFFC;
        e.exp_store = '0;
        e.chk_data  = 1'b1;
        e.exp_fault = 1'b0;
        e.exp_data  = ram_stall ? 32'h0 : ref_mem[a[9:2]];
        e.exp_cyc   = issue + (ram_stall ? TO : ram_lat + 1);
        return e;
    endfunction

    function automatic exp_t mk_data(bit wr, logic [31:0] a, mem_size_t sz, bit sg,
                                     logic [31:0] sd, int issue);
        exp_t        e;
        int          off;
        int          nbytes;
        logic [31:0] w;
        logic [31:0] rep;
        logic [3:0]  lanes;
        off    = int'(a[1:0]);
        nbytes = (sz == MEM_BYTE) ? 1 : (sz == MEM_HALF) ? 2 : 4;
        lanes  = 4'((1 << nbytes) - 1) << off;
        rep    = (sz == MEM_BYTE) ? sd[7:0] * 32'h01010101 :
                 (sz == MEM_HALF) ? sd[15:0] * 32'h00010001 : sd;
        e.fetch     = 1'b0;
        e.exp_addr  = a;
        e.exp_store = rep;
        e.chk_data  = 1'b1;
        e.exp_data  = '0;
        if (off % nbytes != 0) begin
            e.exp_ren   = 1'b0;
            e.exp_wen   = 4'b0000;
            e.exp_fault = 1'b1;
            e.exp_cyc   = issue + 1;
            return e;
        end
        e.exp_ren = !wr;
        e.exp_wen = wr ? lanes : 4'b0000;
        if (ram_stall) begin
            e.exp_fault = 1'b1;
            e.exp_cyc   = issue + TO;
            return e;
        end
        e.exp_fault = 1'b0;
        e.exp_cyc   = issue + ram_lat + 1;
        if (wr) begin
            e.chk_data = 1'b0;
            for (int b = 0; b < 4; b++)
                if (lanes[b]) ref_mem[a[9:2]][8*b +: 8] = rep[8*b +: 8];
        end else begin
            w = ref_mem[a[9:2]] >> (8 * off);
            if (nbytes == 1)      e.exp_data = sg ? 32'($signed(w[7:0]))  : 32'(w[7:0]);
            else if (nbytes == 2) e.exp_data = sg ? 32'($signed(w[15:0])) : 32'(w[15:0]);
            else                  e.exp_data = w;
        end
        return e;
    endfunction

    // Monitor: checks the RAM bus against the head expectation and pops on every hit.
    exp_t mon_e;
    bit   prev_hit = 1'b0;
    always @(negedge clk) begin
        if (!nrst) begin
            prev_hit = 1'b0;
        end else begin
            if (prev_hit) chk("idle_gap", {27'b0, u_ram.ren, u_ram.wen}, 32'h0);
            prev_hit = ihit | dhit;
            if (ram_active) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL bus_unexpected: ren=%0b wen=%b expected no access", u_ram.ren, u_ram.wen);
                end else begin
                    chk("bus_ren", {31'b0, u_ram.ren}, {31'b0, sbq[0].exp_ren});
                    chk("bus_wen", {28'b0, u_ram.wen}, {28'b0, sbq[0].exp_wen});
                    chk("bus_addr", u_ram.addr, sbq[0].exp_addr);
                    if (sbq[0].exp_wen != 4'b0000) chk("bus_store", u_ram.store, sbq[0].exp_store);
                end
            end
            if (ihit) begin n_ihit++; last_iload = iload; end
            if (dhit) begin n_dhit++; last_dload = dload; last_dfault = dfault; end
            if (ihit && dhit) begin
                n_cmp++; n_err++;
                $display("FAIL dual_hit: ihit and dhit both high, expected one");
            end
            if (ihit || dhit) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL hit_unexpected: ihit=%0b dhit=%0b expected none", ihit, dhit);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("hit_kind", {31'b0, ihit}, {31'b0, mon_e.fetch});
                    chk("hit_cycle", 32'(cyc), 32'(mon_e.exp_cyc));
                    chk("dfault", {31'b0, dfault}, {31'b0, mon_e.exp_fault});
                    if (mon_e.chk_data)
                        chk(mon_e.fetch ? "iload" : "dload", mon_e.fetch ? iload : dload, mon_e.exp_data);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        iren = 1'b0; dren = 1'b0; dwen = 1'b0;
    endtask

    task automatic do_req(bit is_fetch, bit wr, logic [31:0] a, mem_size_t sz, bit sg,
                          logic [31:0] sd, bit early_drop);
        int h0;
        h0 = n_ihit + n_dhit;
        if (is_fetch) begin
            sbq.push_back(mk_fetch(a, cyc));
            iren = 1'b1; iaddr = a;
        end else begin
            sbq.push_back(mk_data(wr, a, sz, sg, sd, cyc));
            dren = !wr; dwen = wr; daddr = a; dsize = sz; dsigned = sg; dstore = sd;
        end
        note_grant(!is_fetch);
        for (int k = 0; k < 20 && (n_ihit + n_dhit) == h0; k++) begin
            tick();
            if (early_drop) drop_all();
        end
        if ((n_ihit + n_dhit) == h0) begin
            n_cmp++; n_err++;
            $display("FAIL hit_wait: no hit within 20 cycles, expected one");
            sbq.delete();
        end
        drop_all();
    endtask

    task automatic do_both(logic [31:0] ia, bit wr, logic [31:0] da, mem_size_t sz, bit sg,
                           logic [31:0] sd);
        exp_t ed, ef;
        bit   data_first;
        int   i0, d0;
        i0 = n_ihit; d0 = n_dhit;
        data_first = 1'b1;
`ifdef RAM_MASTER_RR_EN
        data_first = prio_data;
`endif
        if (data_first) begin
            ed = mk_data(wr, da, sz, sg, sd, cyc);
            ef = mk_fetch(ia, ed.exp_cyc + 1);
            sbq.push_back(ed); sbq.push_back(ef);
            note_grant(1'b1); note_grant(1'b0);
        end else begin
            ef = mk_fetch(ia, cyc);
            ed = mk_data(wr, da, sz, sg, sd, ef.exp_cyc + 1);
            sbq.push_back(ef); sbq.push_back(ed);
            note_grant(1'b0); note_grant(1'b1);
        end
        iren = 1'b1; iaddr = ia;
        dren = !wr; dwen = wr; daddr = da; dsize = sz; dsigned = sg; dstore = sd;
        for (int k = 0; k < 30 && (n_ihit == i0 || n_dhit == d0); k++) begin
            tick();
            if (n_ihit != i0) iren = 1'b0;
            if (n_dhit != d0) begin dren = 1'b0; dwen = 1'b0; end
        end
        if (n_ihit == i0 || n_dhit == d0) begin
            n_cmp++; n_err++;
            $display("FAIL both_wait: ihits=%0d dhits=%0d expected one each", n_ihit - i0, n_dhit - d0);
            sbq.delete();
        end
        drop_all();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a, sd;
        mem_size_t   sz;
        int          h0;

        init_ref();
        repeat (3) tick();
        nrst = 1'b1;
        @(negedge clk);
        chk("rst_ihit", {31'b0, ihit}, 32'h0);
        chk("rst_dhit", {31'b0, dhit}, 32'h0);
        chk("rst_dfault", {31'b0, dfault}, 32'h0);
        chk("rst_iload", iload, 32'h0);
        chk("rst_dload", dload, 32'h0);
        chk("rst_ren_wen", {27'b0, u_ram.ren, u_ram.wen}, 32'h0);
        tick();

        ram_lat = 0;
        do_req(0, 1, 32'h100, MEM_WORD, 0, 32'hDEADBEEF, 0);
        do_req(1, 0, 32'h100, MEM_WORD, 0, 32'h0, 0);
        chk("spec_fetch", last_iload, 32'hDEADBEEF);
        do_req(0, 1, 32'h200, MEM_WORD, 0, 32'h8001_1234, 0);
        do_req(0, 0, 32'h202, MEM_HALF, 1, 32'h0, 0);
        chk("spec_half_s", last_dload, 32'hFFFF8001);
        do_req(0, 0, 32'h202, MEM_HALF, 0, 32'h0, 0);
        chk("spec_half_u", last_dload, 32'h00008001);
        do_req(0, 1, 32'h203, MEM_BYTE, 0, 32'h0000_00AB, 0);
        do_req(0, 0, 32'h200, MEM_WORD, 0, 32'h0, 0);
        chk("spec_byte_st", last_dload, 32'hAB01_1234);
        do_req(0, 0, 32'h201, MEM_WORD, 0, 32'h0, 0);
        chk("spec_misalign", {31'b0, last_dfault}, 32'h1);
        do_req(0, 1, 32'h203, MEM_HALF, 0, 32'h1234, 0);

        do_both(32'h104, 0, 32'h200, MEM_BYTE, 1, 32'h0);
        do_both(32'h108, 1, 32'h20C, MEM_HALF, 0, 32'h5A5A);

        ram_lat = 2;
        do_req(0, 0, 32'h200, MEM_WORD, 0, 32'h0, 0);
        do_req(1, 0, 32'h100, MEM_WORD, 0, 32'h0, 1);
        do_req(0, 0, 32'h203, MEM_BYTE, 1, 32'h0, 1);

        ram_stall = 1'b1;
        do_req(0, 0, 32'h300, MEM_WORD, 0, 32'h0, 0);
        chk("spec_timeout", {31'b0, last_dfault}, 32'h1);
        do_req(1, 0, 32'h304, MEM_WORD, 0, 32'h0, 0);
        do_req(0, 1, 32'h308, MEM_WORD, 0, 32'hCAFEF00D, 0);
        ram_stall = 1'b0;
        do_req(0, 0, 32'h308, MEM_WORD, 0, 32'h0, 0);

        for (int n = 0; n < 160; n++) begin
            ram_lat   = $urandom_range(0, 2);
            ram_stall = ($urandom_range(0, 9) == 0);
            a  = 32'($urandom_range(0, 1023));
            sz = mem_size_t'($urandom_range(0, 2));
            sd = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = (sz == MEM_WORD) ? (a & 32'h3FC) : (sz == MEM_HALF) ? (a & 32'h3FE) : a;
            case ($urandom_range(0, 5))
                0: do_req(1, 0, a, sz, 0, sd, 0);
                1, 2: do_req(0, 0, a, sz, $urandom_range(0, 1) == 1, sd, 0);
                3: do_req(0, 1, a, sz, 0, sd, 0);
                4: begin
                    ram_stall = 1'b0;
                    do_both(32'($urandom_range(0, 1023)), $urandom_range(0, 1) == 1, a, sz,
                            $urandom_range(0, 1) == 1, sd);
                end
                default: do_req($urandom_range(0, 1) == 1, 0, a, sz, 1, sd, 1);
            endcase
        end

        ram_stall = 1'b1;
        h0 = n_ihit + n_dhit;
        sbq.push_back(mk_fetch(32'h100, cyc));
        iren = 1'b1; iaddr = 32'h100;
        tick();
        iren = 1'b0;
        tick();
        nrst = 1'b0;
        tick();
        sbq.delete();
        init_ref();
        nrst = 1'b1;
        ram_stall = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_bus", {27'b0, u_ram.ren, u_ram.wen}, 32'h0);
            chk("rst_mid_hit", {30'b0, ihit, dhit}, 32'h0);
        end
        chk("rst_mid_nohit", 32'(n_ihit + n_dhit), 32'(h0));
        tick();
        ram_lat = 1;
        do_req(1, 0, 32'h100, MEM_WORD, 0, 32'h0, 0);
        do_req(0, 0, 32'h102, MEM_HALF, 1, 32'h0, 0);
        repeat (2) tick();
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL global_time: simulation did not finish, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

endmodule
